seq_11011_tx: RTL and testbench
===============================

# seq_11011_tx

Serial framing transmitter that drives a single-bit stream which the overlapping 11011 Moore detector uses for frame alignment. On each accepted request it emits the 5-bit sync word 11011, then a PAYLOAD_W-bit payload MSB-first, then two guard zeros. Zero-stuffing inside the payload guarantees that 11011 never appears on `out` except at the deliberate sync word. The block sits on the transmit side of the link, and its `out` feeds the detector's `in`.

## Interface
- PAYLOAD_W, 8: payload bits per frame (≥1).
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset; low forces reset state immediately.
- start  in  1  frame request; sampled only while `ready`=1.
- data  in  PAYLOAD_W  payload; latched on the edge that accepts `start`.
- ready  out  1  high only in IDLE.
- busy  out  1  inverse of `ready`.
- out  out  1  registered serial bit; 0 when idle.
- sync_flag  out  1  high while `out` carries a sync-word bit.
- stuff_flag  out  1  high while `out` carries an inserted stuff 0.
- done  out  1  one-cycle pulse on the last guard bit.

## Operation
- States:
  - IDLE → SYNC on `start`=1.
  - SYNC (5 bits) → PAYLOAD.
  - PAYLOAD ⇄ STUFF.
  - PAYLOAD (after last payload bit) → GUARD.
  - GUARD (2 bits) → IDLE.
- Sync word: 1,1,0,1,1 in that order, with `sync_flag`=1 for all five bits. No stuffing is applied during SYNC.
- Payload: bits are sent data[PAYLOAD_W-1] down to data[0] from the latched copy. Changes on `data` after acceptance have no effect.
- History register `hist[3:0]`:
  - Holds the last four bits driven on `out`, newest in [0].
  - Updated every cycle in every state, including idle zeros and sync bits.
  - Resets to 0000.
- Stuff rule:
  - Applies in PAYLOAD when `hist`==1101 and payload bits remain.
  - The next bit is then a stuff 0 (STUFF state, `stuff_flag`=1).
  - The stuff bit does not consume a payload bit. Payload resumes the following cycle.
- No stuff is inserted after the final payload bit. GUARD zeros follow directly.
- Guard: two 0 bits. These guarantee that no 11011 can span the payload tail and the next sync word.
- `start` while `busy` is ignored; it is neither queued nor latched.
- Frame length is 5 + PAYLOAD_W + (number of stuffs) + 2 bits.
- Bit counter width is ceil(log2(PAYLOAD_W+1)). The count is exact, with no wrap inside a frame.

## Timing
- Reset (rst=0, asynchronous) forces:
  - state IDLE, `out`=0, `hist`=0000
  - `ready`=1, `busy`=0
  - `sync_flag`=0, `stuff_flag`=0, `done`=0
- Reset mid-frame aborts the frame at once and loses the remaining bits. Operation resumes on the first edge after rst returns high.
- Acceptance at edge k: the first sync bit is on `out` after edge k. `ready` drops at the same edge.
- Sync bits occupy the cycles after edges k..k+4. The first payload bit appears after edge k+5.
- `done`=1 during the second guard bit. At the next edge: state IDLE, `ready`=1, `out`=0.
- Back-to-back frames: `start` held high is accepted on the first IDLE edge. The next sync word therefore starts after ≥3 zeros (2 guard + 1 idle).
- All outputs are registered. There is no combinational path from `start` or `data` to `out`.

## Test plan
- Reset: hold rst=0 for 3 cycles with `start`=1 → `out`=0, `ready`=1, no frame begins. Release reset → a frame starts on the next edge.
- data=8'h00: `out` = 11011 00000000 00 (15 bits). `sync_flag` high for the first 5 bits, no stuffs, `done` on bit 15, `ready` high 1 cycle later.
- data=8'hFF: `out` = 11011 11111111 00 (15 bits), `stuff_flag` never high.
- data=8'h6D: `out` = 11011 0 1 [0] 1 0 1 1 0 1 00 (16 bits). Exactly one stuff, at bit 8. No stuff after the final 1 despite `hist`=1101.
- Random payloads × 200 frames, with `out` fed to the overlapping 11011 detector: detector fires exactly once per frame, on the 5th sync bit. Destuffed payload equals `data`.
- Abort and busy: pull rst low during payload bit 3 → `out`=0 and `ready`=1 immediately. Pulse `start` while `busy` → ignored, and the frame in progress completes unchanged.

Source files
------------

// File: rtl/seq_11011_tx.sv
// seq_11011_tx: serial framing transmitter.
// Each accepted request sends the sync word 11011, then a PAYLOAD_W-bit
// payload MSB-first, then two guard zeros. A zero is stuffed into the
// payload whenever the last four transmitted bits are 1101 and payload
// bits remain, so 11011 can only appear as the deliberate sync word.
module seq_11011_tx #(
  parameter int unsigned PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PAYLOAD_W-1:0] data,
  output logic                 ready,
  output logic                 busy,
  output logic                 out,
  output logic                 sync_flag,
  output logic                 stuff_flag,
  output logic                 done
);

  localparam int unsigned CNT_W     = $clog2(PAYLOAD_W + 1);
  localparam logic [4:0]  SYNC_WORD = 5'b11011;
  localparam logic [3:0]  STUFF_PAT = 4'b1101;

  // The state names the kind of bit currently on `out`.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PAYLOAD,
    S_STUFF,
    S_GUARD
  } state_t;

  state_t               r_state;
  logic [PAYLOAD_W-1:0] r_shift;
  logic [CNT_W-1:0]     r_rem;
  logic [2:0]           r_phase;
  logic [3:0]           r_hist;
  logic                 r_out;
  logic                 r_sync;
  logic                 r_stuff;
  logic                 r_done;
  logic                 r_ready;

  state_t               w_state_nxt;
  logic [PAYLOAD_W-1:0] w_shift_nxt;
  logic [CNT_W-1:0]     w_rem_nxt;
  logic [2:0]           w_phase_nxt;
  logic                 w_out_nxt;
  logic                 w_done_nxt;
  logic                 w_take;

  // Next-state and next-bit selection; the chosen bit is registered onto out.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_rem_nxt   = r_rem;
    w_phase_nxt = r_phase;
    w_out_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_take      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SYNC;
          w_shift_nxt = data;
          w_rem_nxt   = CNT_W'(PAYLOAD_W);
          w_phase_nxt = 3'd0;
          w_out_nxt   = SYNC_WORD[4];
        end
      end

      S_SYNC: begin
        if (r_phase == 3'd4) begin
          w_state_nxt = S_PAYLOAD;
          w_take      = 1'b1;
        end else begin
          w_phase_nxt = r_phase + 3'd1;
          w_out_nxt   = SYNC_WORD[3'd3 - r_phase];
        end
      end

      S_PAYLOAD: begin
        if (r_rem == '0) begin
          w_state_nxt = S_GUARD;
          w_phase_nxt = 3'd0;
        end else if (r_hist == STUFF_PAT) begin
          w_state_nxt = S_STUFF;
        end else begin
          w_take = 1'b1;
        end
      end

      S_STUFF: begin
        w_state_nxt = S_PAYLOAD;
        w_take      = 1'b1;
      end

      S_GUARD: begin
        if (r_phase == 3'd0) begin
          w_phase_nxt = 3'd1;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Shared payload shift: every entry into PAYLOAD consumes one data bit.
    if (w_take) begin
      w_out_nxt   = r_shift[PAYLOAD_W-1];
      w_shift_nxt = r_shift << 1;
      w_rem_nxt   = r_rem - CNT_W'(1);
    end
  end

  // State, payload shifter, counters, bit history and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_rem   <= '0;
      r_phase <= '0;
      r_hist  <= '0;
      r_out   <= 1'b0;
      r_sync  <= 1'b0;
      r_stuff <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_rem   <= w_rem_nxt;
      r_phase <= w_phase_nxt;
      r_hist  <= {r_hist[2:0], w_out_nxt};
      r_out   <= w_out_nxt;
      r_sync  <= (w_state_nxt == S_SYNC);
      r_stuff <= (w_state_nxt == S_STUFF);
      r_done  <= w_done_nxt;
      r_ready <= (w_state_nxt == S_IDLE);
    end
  end

  assign out        = r_out;
  assign sync_flag  = r_sync;
  assign stuff_flag = r_stuff;
  assign done       = r_done;
  assign ready      = r_ready;
  assign busy       = ~r_ready;

endmodule

// File: tb/tb_seq_11011_tx.sv
// Scoreboard bench for seq_11011_tx: stimulus pushes expected per-bit
// entries, a monitor pops one per busy cycle and also runs an overlapping
// 11011 detector and a destuffing receiver on the serial stream.
module tb_seq_11011_tx;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] data;
  logic         ready;
  logic         busy;
  logic         out;
  logic         sync_flag;
  logic         stuff_flag;
  logic         done;

  typedef struct packed {
    logic o;
    logic sy;
    logic st;
    logic dn;
    logic fire;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] data_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [4:0]   det    = '0;
  int           fires  = 0;
  int           pcnt   = 0;
  logic [W-1:0] coll   = '0;
  int           bitno  = 0;

  seq_11011_tx #(.PAYLOAD_W(W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data       (data),
    .ready      (ready),
    .busy       (busy),
    .out        (out),
    .sync_flag  (sync_flag),
    .stuff_flag (stuff_flag),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // '1'/'0' = data bit, 's' = stuff zero; first five chars are the sync word.
  task automatic push_str(input string s, input bit full);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.o    = (s.getc(i) == 8'h31);
      e.st   = (s.getc(i) == 8'h73);
      e.sy   = (i < 5);
      e.dn   = full && (i == s.len() - 1);
      e.fire = (i == 4);
      exp_q.push_back(e);
    end
  endtask

  // Reference framing built from the stuffing rule on the frame's own bits.
  task automatic gen_exp(input logic [W-1:0] d);
    exp_t       e;
    logic [3:0] h;
    push_str("11011", 1'b0);
    h = 4'b1011;
    for (int i = W - 1; i >= 0; i--) begin
      e = '{o: d[i], sy: 1'b0, st: 1'b0, dn: 1'b0, fire: 1'b0};
      exp_q.push_back(e);
      h = {h[2:0], d[i]};
      if (i > 0 && h == 4'b1101) begin
        e = '{o: 1'b0, sy: 1'b0, st: 1'b1, dn: 1'b0, fire: 1'b0};
        exp_q.push_back(e);
        h = {h[2:0], 1'b0};
      end
    end
    e = '{o: 1'b0, sy: 1'b0, st: 1'b0, dn: 1'b0, fire: 1'b0};
    exp_q.push_back(e);
    e.dn = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout act ready=%b required ready=1", ready);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input string s, input bit model);
    wait_ready();
    if (model) gen_exp(d);
    else       push_str(s, 1'b1);
    data_q.push_back(d);
    data  = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    data  = ~d;
  endtask

  // Monitor: one expected entry per busy cycle, idle checks otherwise.
  initial begin
    exp_t         e;
    logic [5:0]   act;
    logic [5:0]   req;
    logic [W-1:0] d;
    forever begin
      @(negedge clk);
      det = {det[3:0], out};
      if (busy) begin
        bitno++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bit act out=%b busy=1 required busy=0", out);
        end else begin
          e   = exp_q.pop_front();
          act = {out, sync_flag, stuff_flag, done, (det == 5'b11011), ready};
          req = {e.o, e.sy, e.st, e.dn, e.fire, 1'b0};
          if (act !== req) begin
            errors++;
            $display("FAIL frame_bit%0d act out/sync/stuff/done/det/ready=%b required %b",
                     bitno, act, req);
          end
        end
        if (det == 5'b11011) fires++;
        if (!sync_flag && !stuff_flag && pcnt < W) begin
          coll = {coll[W-2:0], out};
          pcnt++;
        end
        if (done) begin
          checks++;
          if (data_q.size() == 0) begin
            errors++;
            $display("FAIL frame_end act done=1 required no_frame");
          end else begin
            d = data_q.pop_front();
            if (pcnt != W || coll !== d || fires != 1) begin
              errors++;
              $display("FAIL destuff act data=%h bits=%0d fires=%0d required data=%h bits=%0d fires=1",
                       coll, pcnt, fires, d, W);
            end
          end
          pcnt  = 0;
          fires = 0;
          coll  = '0;
          bitno = 0;
        end
      end else begin
        checks++;
        act = {ready, out, sync_flag, stuff_flag, done, (det == 5'b11011)};
        if (act !== 6'b100000) begin
          errors++;
          $display("FAIL idle act ready/out/sync/stuff/done/det=%b required 100000", act);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    logic [5:0] act;
    int         n;
    rst   = 1'b1;
    start = 1'b1;
    data  = 8'h00;
    #1 rst = 1'b0;

    // Reset held with start high: no frame; frame begins right after release.
    push_str("110110000000000", 1'b1);
    data_q.push_back(8'h00);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    data  = 8'hFF;

    send(8'hFF, "110111111111100", 1'b0);
    send(8'h6D, "1101101s10110100", 1'b0);
    send(8'hDB, "110111101s101100", 1'b0);
    send(8'h5B, "1101101s01101s100", 1'b0);

    // start pulsed while busy must be ignored.
    send(8'h00, "110110000000000", 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Back-to-back frames with start held high.
    wait_ready();
    push_str("1101101s10110100", 1'b1);
    push_str("110111101s101100", 1'b1);
    data_q.push_back(8'h6D);
    data_q.push_back(8'hDB);
    data  = 8'h6D;
    start = 1'b1;
    @(posedge clk);
    #1 data = 8'hDB;
    wait_ready();
    @(posedge clk);
    #1 start = 1'b0;

    // Abort during payload bit 3.
    wait_ready();
    push_str("11011101", 1'b0);
    data  = 8'hA5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    act = {out, ready, busy, sync_flag, stuff_flag, done};
    if (act !== 6'b010000) begin
      errors++;
      $display("FAIL abort act out/ready/busy/sync/stuff/done=%b required 010000", act);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_bits act pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    data_q.delete();
    pcnt  = 0;
    fires = 0;
    coll  = '0;
    bitno = 0;
    @(negedge clk);
    #1 rst = 1'b1;

    // Random payloads through the reference framing and detector.
    for (int f = 0; f < 200; f++) begin
      send(W'($urandom), "", 1'b1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || data_q.size() != 0) begin
      errors++;
      $display("FAIL drain act pending_bits=%0d pending_frames=%0d required 0 0",
               exp_q.size(), data_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
